// File: rtl/ofs_asp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ofs_asp_pkg
// Description : Shared ASP definitions used by the interrupt controller.
//               Holds the platform interrupt line counts, the IRQ CSR word
//               offsets, the hold-off counter width and the IRQ FSM state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ofs_asp_pkg;

  // Platform interrupt topology: DMA read, DMA write, kernel, one spare.
  localparam int ASP_NUM_INTERRUPT_LINES = 4;
  localparam int ASP_NUM_IRQ_USED        = 3;

  // Width of the hold-off register and its down-counter.
  localparam int ASP_IRQ_HOLDOFF_WIDTH   = 16;

  // IRQ CSR window, word offsets.
  localparam int IRQ_CSR_STATUS  = 0;
  localparam int IRQ_CSR_ENABLE  = 1;
  localparam int IRQ_CSR_MODE    = 2;
  localparam int IRQ_CSR_HOLDOFF = 3;
  localparam int IRQ_CSR_RAW     = 4;
  localparam int IRQ_CSR_INFO    = 5;

  // Host request sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } asp_irq_state_e;

endpackage : ofs_asp_pkg
`default_nettype wire

// File: rtl/asp_irq_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : asp_irq_rr_arb
// Description : Combinational round-robin picker. Selects the first asserted
//               request strictly after last_grant_i, wrapping at N.
// Ports       : req_i        - request vector
//               last_grant_i - index of the most recently served line
//               valid_o      - at least one request present
//               grant_o      - one-hot grant
//               idx_o        - index of the granted line
// Revision    : 1.0 - initial release
// ============================================================================
module asp_irq_rr_arb #(
  parameter int N  = 4,
  parameter int VW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [VW-1:0] last_grant_i,
  output logic          valid_o,
  output logic [N-1:0]  grant_o,
  output logic [VW-1:0] idx_o
);

  logic found;

  // Two passes: the lowest request above last_grant wins; failing that the
  // lowest request overall (which must sit at or below last_grant) wins.
  always_comb begin
    found   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (i > int'(last_grant_i))) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = VW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = VW'(i);
      end
    end
  end

  assign valid_o = |req_i;

endmodule : asp_irq_rr_arb
`default_nettype wire

// File: rtl/asp_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : asp_irq_ctrl
// Description : ASP interrupt controller. Latches interrupt sources into
//               pending bits (edge or level per line), masks them with ENABLE
//               and presents one vector at a time to the host through a
//               valid/ack handshake with round-robin arbitration and a
//               programmable hold-off between requests.
// Ports       : clk, reset_n                 - clock, async active-low reset
//               irq_in                       - raw interrupt sources
//               irq_out_valid/vector/ack     - host interrupt handshake
//               csr_*                        - AVMM CSR slave, read latency 1
// Revision    : 1.0 - initial release
// ============================================================================
module asp_irq_ctrl
  import ofs_asp_pkg::*;
#(
  parameter  int NUM_IRQ_LINES  = ASP_NUM_INTERRUPT_LINES,
  parameter  int NUM_IRQ_USED   = ASP_NUM_IRQ_USED,
  parameter  int CSR_DATA_WIDTH = 64,
  parameter  int CSR_ADDR_WIDTH = 3,
  parameter  int HOLDOFF_WIDTH  = ASP_IRQ_HOLDOFF_WIDTH,
  parameter  int MODE_RESET     = 0,
  localparam int VEC_WIDTH      = (NUM_IRQ_LINES > 1) ? $clog2(NUM_IRQ_LINES) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_IRQ_LINES-1:0]    irq_in,
  output logic                        irq_out_valid,
  output logic [VEC_WIDTH-1:0]        irq_out_vector,
  input  logic                        irq_out_ack,
  input  logic [CSR_ADDR_WIDTH-1:0]   csr_address,
  input  logic                        csr_read,
  input  logic                        csr_write,
  input  logic [CSR_DATA_WIDTH-1:0]   csr_writedata,
  input  logic [CSR_DATA_WIDTH/8-1:0] csr_byteenable,
  output logic [CSR_DATA_WIDTH-1:0]   csr_readdata,
  output logic                        csr_readdatavalid,
  output logic                        csr_waitrequest
);

  localparam int N  = NUM_IRQ_LINES;
  localparam int HW = HOLDOFF_WIDTH;

  // Lines at or above NUM_IRQ_USED never hold state.
  localparam logic [N-1:0] USED_MASK = (NUM_IRQ_USED >= N) ? {N{1'b1}}
                                     : N'((64'd1 << NUM_IRQ_USED) - 64'd1);

  logic [N-1:0]  raw_q, raw_prev_q;
  logic [N-1:0]  pending_q, pending_d, sent_q, sent_d;
  logic [N-1:0]  enable_q, enable_d, mode_q, mode_d;
  logic [HW-1:0] holdoff_q, holdoff_d, cnt_q, cnt_d;
  asp_irq_state_e state_q, state_d;
  logic [VEC_WIDTH-1:0] vec_q, vec_d, last_q, last_d;
  logic          has_last_q, has_last_d;
  logic [N-1:0]  vec_oh_q, vec_oh_d;
  logic [CSR_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic          rvalid_q;

  // ---------------- CSR write decode ----------------
  logic [CSR_DATA_WIDTH-1:0] be_mask;
  for (genvar b = 0; b < CSR_DATA_WIDTH/8; b++) begin : g_be_mask
    assign be_mask[8*b +: 8] = {8{csr_byteenable[b]}};
  end

  logic          wr_status, wr_enable, wr_mode, wr_holdoff;
  logic [N-1:0]  wmask, wdata, w1c;

  assign wr_status  = csr_write && (csr_address == CSR_ADDR_WIDTH'(IRQ_CSR_STATUS));
  assign wr_enable  = csr_write && (csr_address == CSR_ADDR_WIDTH'(IRQ_CSR_ENABLE));
  assign wr_mode    = csr_write && (csr_address == CSR_ADDR_WIDTH'(IRQ_CSR_MODE));
  assign wr_holdoff = csr_write && (csr_address == CSR_ADDR_WIDTH'(IRQ_CSR_HOLDOFF));
  assign wmask      = be_mask[N-1:0];
  assign wdata      = csr_writedata[N-1:0];
  assign w1c        = wr_status ? (wdata & wmask) : '0;

  assign enable_d  = wr_enable ? (((enable_q & ~wmask) | (wdata & wmask)) & USED_MASK) : enable_q;
  assign mode_d    = wr_mode   ? (((mode_q   & ~wmask) | (wdata & wmask)) & USED_MASK) : mode_q;
  assign holdoff_d = wr_holdoff ? ((holdoff_q & ~be_mask[HW-1:0]) |
                                   (csr_writedata[HW-1:0] & be_mask[HW-1:0])) : holdoff_q;

  // ---------------- Pending / sent tracking ----------------
  logic [N-1:0] set_vec, eligible;
  logic         ack_fire;

  assign set_vec   = ((mode_q & raw_q & ~raw_prev_q) | (~mode_q & raw_q)) & USED_MASK;
  assign pending_d = ((pending_q & ~w1c) | set_vec) & USED_MASK;
  assign ack_fire  = (state_q == REQ) && irq_out_ack;
  // A W1C re-arms the line even when a level source immediately re-sets
  // pending, so each software clear yields exactly one more request.
  assign sent_d    = (sent_q | (ack_fire ? vec_oh_q : '0)) & ~w1c;
  assign eligible  = pending_q & enable_q & ~sent_q;

  // ---------------- Arbitration ----------------
  logic                 arb_valid;
  logic [N-1:0]         arb_grant;
  logic [VEC_WIDTH-1:0] arb_idx, arb_last;

  // Before the first grant, pretend the top line was served so line 0 leads.
  assign arb_last = has_last_q ? last_q : VEC_WIDTH'(N - 1);

  asp_irq_rr_arb #(
    .N  (N),
    .VW (VEC_WIDTH)
  ) u_rr_arb (
    .req_i        (eligible),
    .last_grant_i (arb_last),
    .valid_o      (arb_valid),
    .grant_o      (arb_grant),
    .idx_o        (arb_idx)
  );

  // ---------------- Request sequencer ----------------
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    vec_oh_d   = vec_oh_q;
    last_d     = last_q;
    has_last_d = has_last_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          vec_d    = arb_idx;
          vec_oh_d = arb_grant;
          state_d  = REQ;
        end
      end
      REQ: begin
        // Held until acked, regardless of later ENABLE/pending changes.
        if (irq_out_ack) begin
          last_d     = vec_q;
          has_last_d = 1'b1;
          cnt_d      = holdoff_q;
          state_d    = (holdoff_q != '0) ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (cnt_q <= HW'(1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- CSR read mux (pre-write values) ----------------
  always_comb begin
    rdata_d = '0;
    if (csr_read) begin
      case (csr_address)
        CSR_ADDR_WIDTH'(IRQ_CSR_STATUS):  rdata_d[N-1:0]  = pending_q;
        CSR_ADDR_WIDTH'(IRQ_CSR_ENABLE):  rdata_d[N-1:0]  = enable_q;
        CSR_ADDR_WIDTH'(IRQ_CSR_MODE):    rdata_d[N-1:0]  = mode_q;
        CSR_ADDR_WIDTH'(IRQ_CSR_HOLDOFF): rdata_d[HW-1:0] = holdoff_q;
        CSR_ADDR_WIDTH'(IRQ_CSR_RAW):     rdata_d[N-1:0]  = raw_q & USED_MASK;
        CSR_ADDR_WIDTH'(IRQ_CSR_INFO): begin
          rdata_d[7:0]  = 8'(NUM_IRQ_LINES);
          rdata_d[15:8] = 8'(NUM_IRQ_USED);
        end
        default: rdata_d = '0;
      endcase
    end
  end

  // ---------------- State registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raw_q      <= '0;
      raw_prev_q <= '0;
      pending_q  <= '0;
      sent_q     <= '0;
      enable_q   <= '0;
      mode_q     <= N'(MODE_RESET) & USED_MASK;
      holdoff_q  <= '0;
      cnt_q      <= '0;
      state_q    <= IDLE;
      vec_q      <= '0;
      vec_oh_q   <= '0;
      last_q     <= '0;
      has_last_q <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      raw_q      <= irq_in;
      raw_prev_q <= raw_q;
      pending_q  <= pending_d;
      sent_q     <= sent_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      holdoff_q  <= holdoff_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      vec_q      <= vec_d;
      vec_oh_q   <= vec_oh_d;
      last_q     <= last_d;
      has_last_q <= has_last_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= csr_read;
    end
  end

  assign irq_out_valid     = (state_q == REQ);
  assign irq_out_vector    = vec_q;
  assign csr_readdata      = rdata_q;
  assign csr_readdatavalid = rvalid_q;
  assign csr_waitrequest   = 1'b0;

  // Upper data/byte-lane bits have no destination in this register map.
  logic unused_ok;
  assign unused_ok = ^{csr_writedata, be_mask};

endmodule : asp_irq_ctrl
`default_nettype wire

// File: tb/tb_asp_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_asp_irq_ctrl
// Description : Self-checking bench for asp_irq_ctrl (default parameters).
//               Expected vectors are queued when interrupts are driven and
//               popped when the controller raises a request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asp_irq_ctrl;

  localparam int N  = 4;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  irq_in = '0;
  logic          irq_out_valid;
  logic [1:0]    irq_out_vector;
  logic          irq_out_ack = 1'b0;
  logic [2:0]    csr_address = '0;
  logic          csr_read = 1'b0;
  logic          csr_write = 1'b0;
  logic [DW-1:0] csr_writedata = '0;
  logic [7:0]    csr_byteenable = '0;
  logic [DW-1:0] csr_readdata;
  logic          csr_readdatavalid;
  logic          csr_waitrequest;

  int checks = 0;
  int errors = 0;
  int exp_vec[$];

  asp_irq_ctrl dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .irq_in            (irq_in),
    .irq_out_valid     (irq_out_valid),
    .irq_out_vector    (irq_out_vector),
    .irq_out_ack       (irq_out_ack),
    .csr_address       (csr_address),
    .csr_read          (csr_read),
    .csr_write         (csr_write),
    .csr_writedata     (csr_writedata),
    .csr_byteenable    (csr_byteenable),
    .csr_readdata      (csr_readdata),
    .csr_readdatavalid (csr_readdatavalid),
    .csr_waitrequest   (csr_waitrequest)
  );

  always #5 clk = ~clk;

  // ---------------- bus/stimulus tasks (no checking) ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0; irq_in = '0; irq_out_ack = 1'b0; csr_read = 1'b0; csr_write = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    exp_vec.delete();
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [63:0] d, input logic [7:0] be);
    csr_address = a; csr_writedata = d; csr_byteenable = be; csr_write = 1'b1;
    tick(1);
    csr_write = 1'b0; csr_byteenable = '0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [63:0] d, output logic v);
    csr_address = a; csr_read = 1'b1;
    tick(1);
    csr_read = 1'b0;
    d = csr_readdata; v = csr_readdatavalid;
  endtask

  task automatic pulse(input logic [3:0] m);
    irq_in = irq_in | m;
    tick(1);
    irq_in = irq_in & ~m;
  endtask

  task automatic wait_valid(input int budget, output bit got, output int n);
    n = 0;
    while (!irq_out_valid && n < budget) begin
      tick(1);
      n++;
    end
    got = irq_out_valid;
  endtask

  task automatic do_ack();
    irq_out_ack = 1'b1;
    tick(1);
    irq_out_ack = 1'b0;
  endtask

  task automatic quiet(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      tick(1);
      if (irq_out_valid) seen++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [63:0] d; logic v;
    logic [63:0] exp_r [8];
    exp_r = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h304, 64'h0, 64'h0};
    apply_reset();
    checks++;
    if (irq_out_valid !== 1'b0 || irq_out_vector !== 2'd0 || csr_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b vector=%0d waitreq=%b required 0/0/0",
               irq_out_valid, irq_out_vector, csr_waitrequest);
    end
    for (int a = 0; a < 8; a++) begin
      csr_rd(3'(a), d, v);
      checks++;
      if (v !== 1'b1 || d !== exp_r[a]) begin
        errors++;
        $display("FAIL reset_csr[%0d]: got %h rdv=%b required %h rdv=1", a, d, v, exp_r[a]);
      end
    end
  endtask

  task automatic test_edge();
    logic [63:0] d; logic v; bit got; int n, seen, ev;
    csr_wr(3'd1, 64'h7, 8'hFF);
    csr_wr(3'd2, 64'h7, 8'hFF);
    csr_wr(3'd3, 64'h0, 8'hFF);
    exp_vec.push_back(1);
    irq_in[1] = 1'b1; tick(1); irq_in[1] = 1'b0; tick(1);
    checks++;
    if (irq_out_valid !== 1'b0) begin
      errors++; $display("FAIL edge_latency_early: valid=%b required 0", irq_out_valid);
    end
    tick(1);
    ev = exp_vec.pop_front();
    checks++;
    if (irq_out_valid !== 1'b1 || irq_out_vector !== 2'(ev)) begin
      errors++;
      $display("FAIL edge_latency: valid=%b vector=%0d required 1/%0d", irq_out_valid, irq_out_vector, ev);
    end
    do_ack();
    quiet(10, seen);
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL edge_single_request: valid cycles %0d required 0", seen); end
    csr_rd(3'd0, d, v);
    checks++;
    if (d !== 64'h2) begin errors++; $display("FAIL edge_status: got %h required 2", d); end
    csr_wr(3'd0, 64'h2, 8'hFF);
    csr_rd(3'd0, d, v);
    checks++;
    if (d !== 64'h0) begin errors++; $display("FAIL edge_w1c: got %h required 0", d); end
    exp_vec.push_back(1);
    pulse(4'b0010);
    wait_valid(10, got, n);
    checks++;
    if (!got) begin
      errors++; $display("FAIL edge_repulse_timeout: valid=0 required 1");
    end else begin
      ev = exp_vec.pop_front();
      checks++;
      if (irq_out_vector !== 2'(ev)) begin
        errors++; $display("FAIL edge_repulse_vector: got %0d required %0d", irq_out_vector, ev);
      end
      do_ack();
    end
    csr_wr(3'd0, 64'h2, 8'hFF);
  endtask

  task automatic test_level();
    logic [63:0] d; logic v; bit got; int n, seen, ev;
    csr_wr(3'd2, 64'h0, 8'hFF);
    irq_in[0] = 1'b1;
    for (int round = 0; round < 2; round++) begin
      exp_vec.push_back(0);
      wait_valid(10, got, n);
      checks++;
      if (!got) begin
        errors++; $display("FAIL level_req_timeout[%0d]: valid=0 required 1", round);
      end else begin
        ev = exp_vec.pop_front();
        checks++;
        if (irq_out_vector !== 2'(ev)) begin
          errors++; $display("FAIL level_vector[%0d]: got %0d required %0d", round, irq_out_vector, ev);
        end
        do_ack();
      end
      quiet(10, seen);
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL level_one_per_clear[%0d]: valid cycles %0d required 0", round, seen); end
      csr_rd(3'd0, d, v);
      checks++;
      if (d !== 64'h1) begin errors++; $display("FAIL level_status[%0d]: got %h required 1", round, d); end
      csr_wr(3'd0, 64'h1, 8'hFF);
      if (round == 0) begin
        csr_rd(3'd0, d, v);
        checks++;
        if (d !== 64'h1) begin errors++; $display("FAIL level_reset_after_w1c: got %h required 1", d); end
      end
    end
    // The final W1C above re-armed line 0 once more; serve it, then drop the source.
    wait_valid(10, got, n);
    if (got) do_ack();
    irq_in[0] = 1'b0;
    tick(3);
    csr_wr(3'd0, 64'h1, 8'hFF);
    csr_rd(3'd0, d, v);
    checks++;
    if (d !== 64'h0) begin errors++; $display("FAIL level_clear_low: got %h required 0", d); end
  endtask

  task automatic test_round_robin();
    bit got; int n, ev;
    apply_reset();
    csr_wr(3'd1, 64'h7, 8'hFF);
    csr_wr(3'd2, 64'h7, 8'hFF);
    exp_vec.push_back(0); exp_vec.push_back(1); exp_vec.push_back(2);
    pulse(4'b0111);
    for (int k = 0; k < 4; k++) begin
      wait_valid(20, got, n);
      checks++;
      if (!got || exp_vec.size() == 0) begin
        errors++; $display("FAIL rr_timeout[%0d]: valid=%b queued=%0d required 1", k, got, exp_vec.size());
      end else begin
        ev = exp_vec.pop_front();
        checks++;
        if (irq_out_vector !== 2'(ev)) begin
          errors++; $display("FAIL rr_order[%0d]: got %0d required %0d", k, irq_out_vector, ev);
        end
        do_ack();
      end
      if (k == 0) begin
        csr_wr(3'd0, 64'h1, 8'hFF);
        exp_vec.push_back(0);
        pulse(4'b0001);
      end
    end
    csr_wr(3'd0, 64'h7, 8'hFF);
  endtask

  task automatic test_holdoff();
    bit got; int n, gap, ev;
    apply_reset();
    csr_wr(3'd1, 64'h7, 8'hFF);
    csr_wr(3'd2, 64'h7, 8'hFF);
    csr_wr(3'd3, 64'd10, 8'hFF);
    exp_vec.push_back(0); exp_vec.push_back(2);
    pulse(4'b0101);
    wait_valid(10, got, n);
    ev = exp_vec.pop_front();
    checks++;
    if (!got || irq_out_vector !== 2'(ev)) begin
      errors++; $display("FAIL hold_first: valid=%b vector=%0d required 1/%0d", got, irq_out_vector, ev);
    end
    do_ack();
    // Rewrite HOLDOFF while the 10-cycle hold-off is running.
    csr_address = 3'd3; csr_writedata = 64'd3; csr_byteenable = 8'hFF; csr_write = 1'b1;
    tick(1);
    csr_write = 1'b0; csr_byteenable = '0;
    gap = 1;
    while (!irq_out_valid && gap < 40) begin tick(1); gap++; end
    checks++;
    if (gap !== 11) begin errors++; $display("FAIL hold_gap10: got %0d cycles required 11", gap); end
    ev = exp_vec.pop_front();
    checks++;
    if (irq_out_vector !== 2'(ev)) begin
      errors++; $display("FAIL hold_second_vector: got %0d required %0d", irq_out_vector, ev);
    end
    exp_vec.push_back(1);
    pulse(4'b0010);
    do_ack();
    gap = 0;
    while (!irq_out_valid && gap < 40) begin tick(1); gap++; end
    checks++;
    if (gap !== 4) begin errors++; $display("FAIL hold_gap3: got %0d cycles required 4", gap); end
    ev = exp_vec.pop_front();
    checks++;
    if (irq_out_vector !== 2'(ev)) begin
      errors++; $display("FAIL hold_third_vector: got %0d required %0d", irq_out_vector, ev);
    end
    do_ack();
  endtask

  task automatic test_masked();
    logic [63:0] d; logic v; bit got; int n, seen, ev;
    apply_reset();
    csr_wr(3'd1, 64'hF, 8'hFF);
    csr_rd(3'd1, d, v);
    checks++;
    if (d !== 64'h7) begin errors++; $display("FAIL mask_enable_rb: got %h required 7", d); end
    csr_wr(3'd2, 64'hF, 8'hFF);
    csr_rd(3'd2, d, v);
    checks++;
    if (d !== 64'h7) begin errors++; $display("FAIL mask_mode_rb: got %h required 7", d); end
    csr_wr(3'd1, 64'h5, 8'hFF);
    irq_in = 4'b1010;
    tick(2);
    csr_rd(3'd4, d, v);
    checks++;
    if (d !== 64'h2) begin errors++; $display("FAIL mask_raw: got %h required 2", d); end
    quiet(8, seen);
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mask_no_request: valid cycles %0d required 0", seen); end
    csr_rd(3'd0, d, v);
    checks++;
    if (d !== 64'h2) begin errors++; $display("FAIL mask_status: got %h required 2", d); end
    irq_in = '0;
    exp_vec.push_back(1);
    csr_wr(3'd1, 64'h7, 8'hFF);
    wait_valid(10, got, n);
    checks++;
    if (!got) begin
      errors++; $display("FAIL mask_enable_req: valid=0 required 1");
    end else begin
      ev = exp_vec.pop_front();
      checks++;
      if (irq_out_vector !== 2'(ev)) begin
        errors++; $display("FAIL mask_enable_vector: got %0d required %0d", irq_out_vector, ev);
      end
      do_ack();
    end
    csr_wr(3'd3, 64'hABCD, 8'h01);
    csr_rd(3'd3, d, v);
    checks++;
    if (d !== 64'hCD) begin errors++; $display("FAIL byteenable: got %h required cd", d); end
  endtask

  task automatic test_csr_timing_reset();
    logic [63:0] d; logic v; bit got; int n, seen;
    apply_reset();
    checks++;
    if (csr_readdatavalid !== 1'b0) begin errors++; $display("FAIL rdv_idle: got %b required 0", csr_readdatavalid); end
    csr_address = 3'd5; csr_read = 1'b1;
    tick(1);
    csr_read = 1'b0;
    checks++;
    if (csr_readdatavalid !== 1'b1 || csr_readdata !== 64'h304) begin
      errors++; $display("FAIL info_read: got %h rdv=%b required 304 rdv=1", csr_readdata, csr_readdatavalid);
    end
    tick(1);
    checks++;
    if (csr_readdatavalid !== 1'b0) begin errors++; $display("FAIL rdv_pulse: got %b required 0", csr_readdatavalid); end
    csr_wr(3'd1, 64'h7, 8'hFF);
    csr_address = 3'd1; csr_writedata = 64'h3; csr_byteenable = 8'hFF;
    csr_read = 1'b1; csr_write = 1'b1;
    tick(1);
    csr_read = 1'b0; csr_write = 1'b0; csr_byteenable = '0;
    checks++;
    if (csr_readdatavalid !== 1'b1 || csr_readdata !== 64'h7) begin
      errors++; $display("FAIL rw_same_addr: got %h required 7 (pre-write)", csr_readdata);
    end
    csr_rd(3'd1, d, v);
    checks++;
    if (d !== 64'h3) begin errors++; $display("FAIL rw_after: got %h required 3", d); end
    csr_wr(3'd2, 64'h7, 8'hFF);
    csr_wr(3'd3, 64'h5, 8'hFF);
    pulse(4'b0001);
    wait_valid(10, got, n);
    checks++;
    if (!got) begin errors++; $display("FAIL reset_pre_valid: valid=0 required 1"); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (irq_out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b required 0", irq_out_valid); end
    tick(2);
    reset_n = 1'b1;
    tick(1);
    for (int a = 0; a < 4; a++) begin
      csr_rd(3'(a), d, v);
      checks++;
      if (v !== 1'b1 || d !== 64'h0) begin
        errors++; $display("FAIL post_reset_csr[%0d]: got %h rdv=%b required 0 rdv=1", a, d, v);
      end
    end
    quiet(5, seen);
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL post_reset_quiet: valid cycles %0d required 0", seen); end
    exp_vec.delete();
  endtask

  initial begin
    test_reset();
    test_edge();
    test_level();
    test_round_robin();
    test_holdoff();
    test_masked();
    test_csr_timing_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_asp_irq_ctrl
`default_nettype wire
